// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the RV32 integer/FP pipeline. It sits beside
// the EX-stage forwarding unit and produces the front-end stage enables, the
// IF/ID and ID/EX flushes and an EX/MEM bubble for three situations:
//   * load-use hazards that forwarding cannot cover (a load's data is not
//     forwardable from MEM, so the consumer has to wait one cycle),
//   * multi-cycle FP operations (FMA class, fdiv/fsqrt) that hold EX,
//   * branch/jump redirects resolved in EX.
// Register address 0 never creates a hazard, matching the forwarding policy.
//
// Parameters
//   FMA_LAT   EX occupancy (cycles) of an FMA-class op, legal 2..16
//   FDIV_LAT  EX occupancy (cycles) of an fdiv/fsqrt op, legal 2..16
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   id_rs{1,2,3}_addr_i           source register addresses in ID
//   id_rs_used_i[n]               rs(n+1) is read by the ID instruction
//   id_rs_f_i[n]                  rs(n+1) comes from the FP file (else integer)
//   ex_valid_i                    EX holds a valid instruction
//   ex_rd_addr_i                  EX destination address
//   ex_rd_wren_I_i/_F_i           EX writes the integer / FP register file
//   ex_wb_sel_i                   EX writeback select, 3'b010 = load
//   ex_mc_start_i, ex_mc_kind_i   EX op is multi-cycle; 0 = FMA, 1 = fdiv/fsqrt
//   ex_redirect_i                 taken branch/jump mispredict resolved in EX
//   pc_en_o, if_id_en_o,
//   id_ex_en_o                    stage register enables
//   if_id_flush_o, id_ex_flush_o  synchronous flush (bubble) of IF/ID, ID/EX
//   ex_mem_bubble_o               write a bubble into EX/MEM this cycle
//   mc_busy_o                     multi-cycle op in progress (MC_WAIT state)
//   stall_cycles_o                saturating count of cycles with pc_en_o = 0
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned FMA_LAT  = 3,
  parameter int unsigned FDIV_LAT = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rs3_addr_i,
  input  logic [2:0]  id_rs_used_i,
  input  logic [2:0]  id_rs_f_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_wren_I_i,
  input  logic        ex_rd_wren_F_i,
  input  logic [2:0]  ex_wb_sel_i,
  input  logic        ex_mc_start_i,
  input  logic        ex_mc_kind_i,
  input  logic        ex_redirect_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_bubble_o,
  output logic        mc_busy_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic [2:0] WB_SEL_LOAD = 3'b010;

  // The trigger cycle (in RUN) and the release cycle (cnt == 0) each take one
  // EX cycle, so the down-counter starts at LAT-2 for exactly LAT cycles in EX.
  localparam logic [3:0] FMA_CNT  = 4'(FMA_LAT - 2);
  localparam logic [3:0] FDIV_CNT = 4'(FDIV_LAT - 2);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_q, stall_d;

  // ---------------------------------------------------------------------------
  // Load-use detection
  // ---------------------------------------------------------------------------
  logic [4:0] id_rs_addr [3];
  logic [2:0] src_hit;
  logic       ex_is_load;
  logic       lu;

  assign id_rs_addr[0] = id_rs1_addr_i;
  assign id_rs_addr[1] = id_rs2_addr_i;
  assign id_rs_addr[2] = id_rs3_addr_i;

  // x0 is hard-wired zero and never produces a dependency.
  assign ex_is_load = ex_valid_i
                    & (ex_wb_sel_i == WB_SEL_LOAD)
                    & (ex_rd_addr_i != 5'd0);

  // A source only conflicts when it reads the same register file the load
  // writes: f5 and x5 share an address but are different registers.
  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    assign src_hit[gi] = id_rs_used_i[gi]
                       & (id_rs_addr[gi] == ex_rd_addr_i)
                       & (id_rs_f_i[gi] ? ex_rd_wren_F_i : ex_rd_wren_I_i);
  end

  assign lu = ex_is_load & (|src_hit);

  // ---------------------------------------------------------------------------
  // Control FSM: next state and raw (pre-reset) outputs
  // ---------------------------------------------------------------------------
  logic pc_en_c;
  logic if_id_en_c;
  logic id_ex_en_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic bubble_c;
  logic busy_c;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en_c       = 1'b1;
    if_id_en_c    = 1'b1;
    id_ex_en_c    = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    bubble_c      = 1'b0;
    busy_c        = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (ex_redirect_i) begin
          // The instructions in IF/ID and ID/EX are on the wrong path, so any
          // hazard they would raise is moot; fetch from the new target.
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (ex_mc_start_i && ex_valid_i) begin
          pc_en_c    = 1'b0;
          if_id_en_c = 1'b0;
          id_ex_en_c = 1'b0;
          bubble_c   = 1'b1;
          cnt_d      = ex_mc_kind_i ? FDIV_CNT : FMA_CNT;
          state_d    = ST_MC_WAIT;
        end else if (lu) begin
          // Hold IF and ID, insert one bubble into EX behind the load.
          pc_en_c       = 1'b0;
          if_id_en_c    = 1'b0;
          id_ex_flush_c = 1'b1;
        end
      end

      ST_MC_WAIT: begin
        // The held op keeps presenting ex_mc_start_i; it is deliberately not
        // looked at here so it cannot retrigger.
        busy_c = 1'b1;
        if (cnt_q != 4'd0) begin
          pc_en_c    = 1'b0;
          if_id_en_c = 1'b0;
          id_ex_en_c = 1'b0;
          bubble_c   = 1'b1;
          cnt_d      = cnt_q - 4'd1;
        end else begin
          // Release cycle: the op leaves EX with its result, pipeline moves.
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall cycle counter (saturating)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_d = stall_q;
    if (!pc_en_c && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset forces a frozen, flushed front end combinationally so the
  // pipeline is quiesced the instant rst_ni falls, even mid multi-cycle op.
  // ---------------------------------------------------------------------------
  assign pc_en_o         = rst_ni & pc_en_c;
  assign if_id_en_o      = rst_ni & if_id_en_c;
  assign id_ex_en_o      = rst_ni & id_ex_en_c;
  assign if_id_flush_o   = ~rst_ni | if_id_flush_c;
  assign id_ex_flush_o   = ~rst_ni | id_ex_flush_c;
  assign ex_mem_bubble_o = rst_ni & bubble_c;
  assign mc_busy_o       = rst_ni & busy_c;
  assign stall_cycles_o  = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Randomized plus directed bench for hazard_ctrl. Each cycle the stimulus
// process drives inputs shortly after the rising edge, asks a behavioural
// model for the expected outputs and pushes them into a queue; a monitor
// pops one entry per falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int unsigned FMA_LAT  = 3;
  localparam int unsigned FDIV_LAT = 12;

  logic        clk;
  logic        rst_ni;
  logic [4:0]  rs1, rs2, rs3;
  logic [2:0]  rs_used, rs_f;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        wren_i, wren_f;
  logic [2:0]  wb_sel;
  logic        mc_start, mc_kind, redirect;
  logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
  logic        bubble, busy;
  logic [31:0] stall_cnt;

  hazard_ctrl #(
    .FMA_LAT  (FMA_LAT),
    .FDIV_LAT (FDIV_LAT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .id_rs1_addr_i   (rs1),
    .id_rs2_addr_i   (rs2),
    .id_rs3_addr_i   (rs3),
    .id_rs_used_i    (rs_used),
    .id_rs_f_i       (rs_f),
    .ex_valid_i      (ex_valid),
    .ex_rd_addr_i    (ex_rd),
    .ex_rd_wren_I_i  (wren_i),
    .ex_rd_wren_F_i  (wren_f),
    .ex_wb_sel_i     (wb_sel),
    .ex_mc_start_i   (mc_start),
    .ex_mc_kind_i    (mc_kind),
    .ex_redirect_i   (redirect),
    .pc_en_o         (pc_en),
    .if_id_en_o      (if_id_en),
    .id_ex_en_o      (id_ex_en),
    .if_id_flush_o   (if_id_flush),
    .id_ex_flush_o   (id_ex_flush),
    .ex_mem_bubble_o (bubble),
    .mc_busy_o       (busy),
    .stall_cycles_o  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  en;     // {pc, if_id, id_ex}
    logic [1:0]  fl;     // {if_id, id_ex}
    logic        bub;
    logic        busy;
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: number of cycles still owed to a multi-cycle op
  // (the last of them is the release cycle) and the running stall count.
  int          m_mc_left = 0;
  logic [31:0] m_stall   = 32'd0;

  // Observations for the directed occupancy checks.
  int obs_pc_low = 0;
  int obs_busy   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic model_lu();
    logic [4:0] src [3];
    logic       hit;
    src[0] = rs1; src[1] = rs2; src[2] = rs3;
    hit = 1'b0;
    if (ex_valid && wb_sel == 3'b010 && ex_rd != 5'd0) begin
      for (int n = 0; n < 3; n++) begin
        if (rs_used[n] && src[n] == ex_rd && (rs_f[n] ? wren_f : wren_i)) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Expected outputs for the current inputs, then advance the model by one clock.
  task automatic model_step(output exp_t e);
    e.stall = m_stall;
    e.busy  = 1'b0;
    e.bub   = 1'b0;
    e.fl    = 2'b00;
    e.en    = 3'b111;
    if (!rst_ni) begin
      e.en      = 3'b000;
      e.fl      = 2'b11;
      e.stall   = 32'd0;
      m_mc_left = 0;
      m_stall   = 32'd0;
      return;
    end
    if (m_mc_left > 0) begin
      e.busy = 1'b1;
      if (m_mc_left > 1) begin
        e.en  = 3'b000;
        e.bub = 1'b1;
      end
      m_mc_left--;
    end else if (redirect) begin
      e.fl = 2'b11;
    end else if (mc_start && ex_valid) begin
      e.en      = 3'b000;
      e.bub     = 1'b1;
      // LAT cycles in EX: this one plus LAT-1 in the wait state.
      m_mc_left = int'(mc_kind ? FDIV_LAT : FMA_LAT) - 1;
    end else if (model_lu()) begin
      e.en = 3'b001;
      e.fl = 2'b01;
    end
    if (!e.en[2] && m_stall != 32'hFFFF_FFFF) m_stall++;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    exp_t e;
    model_step(e);
    q.push_back(e);
    #5;
    if (!pc_en) obs_pc_low++;
    if (busy)   obs_busy++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0; rs_used = 3'b000; rs_f = 3'b000;
    ex_valid = 1'b0; ex_rd = 5'd0; wren_i = 1'b0; wren_f = 1'b0; wb_sel = 3'b000;
    mc_start = 1'b0; mc_kind = 1'b0; redirect = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic fp);
    ex_valid = 1'b1; ex_rd = rd; wb_sel = 3'b010; wren_i = ~fp; wren_f = fp;
  endtask

  // Multi-cycle op held in EX with ex_mc_start_i asserted the whole time.
  task automatic run_mc(input logic kind, input int n_cyc, input int exp_stall,
                        input string name);
    int st0;
    idle();
    ex_valid = 1'b1; mc_start = 1'b1; mc_kind = kind; ex_rd = 5'd3; wren_f = 1'b1;
    obs_pc_low = 0; obs_busy = 0;
    st0 = int'(m_stall);
    repeat (n_cyc) cycle();
    check({name, "_pc_low"}, obs_pc_low, exp_stall);
    check({name, "_busy"},   obs_busy,   exp_stall);
    check({name, "_stall_cnt"}, int'(m_stall) - st0, exp_stall);
    idle();
  endtask

  // Monitor: one comparison group per cycle.
  int mon_cyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        mon_cyc++;
        $display("cyc %0d rst_n=%b en=%b%b%b fl=%b%b bub=%b busy=%b stall=%0d",
                 mon_cyc, rst_ni, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
                 bubble, busy, stall_cnt);
        check("enables", {29'd0, pc_en, if_id_en, id_ex_en}, {29'd0, e.en});
        check("flushes", {30'd0, if_id_flush, id_ex_flush}, {30'd0, e.fl});
        check("bubble",  {31'd0, bubble}, {31'd0, e.bub});
        check("mc_busy", {31'd0, busy},   {31'd0, e.busy});
        check("stall_cycles", stall_cnt, e.stall);
      end
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    // Reset state.
    repeat (2) cycle();
    rst_ni = 1'b1;
    cycle();

    // Integer load-use on rs1.
    set_load(5'd5, 1'b0); rs1 = 5'd5; rs_used = 3'b001;
    cycle();
    idle(); cycle();
    check("lu_int_stall_total", int'(m_stall), 1);

    // No false stall: rd = x0, and FP source vs integer-only write.
    set_load(5'd0, 1'b0); rs1 = 5'd0; rs_used = 3'b001;
    cycle();
    set_load(5'd5, 1'b0); rs1 = 5'd5; rs_used = 3'b001; rs_f = 3'b001;
    cycle();
    idle(); cycle();

    // FP load-use on rs3 (fmadd, all FP sources).
    set_load(5'd7, 1'b1); rs1 = 5'd1; rs2 = 5'd2; rs3 = 5'd7;
    rs_used = 3'b111; rs_f = 3'b111;
    cycle();
    idle(); cycle();

    // fdiv then FMA, run a little past the release.
    run_mc(1'b1, FDIV_LAT, FDIV_LAT - 1, "fdiv");
    cycle();
    run_mc(1'b0, FMA_LAT, FMA_LAT - 1, "fma");
    cycle();

    // Redirect together with a load-use and a multi-cycle start.
    set_load(5'd9, 1'b0); rs2 = 5'd9; rs_used = 3'b010;
    mc_start = 1'b1; redirect = 1'b1;
    obs_busy = 0;
    cycle();
    redirect = 1'b0; mc_start = 1'b0; ex_valid = 1'b0;
    cycle();
    check("redirect_no_mc", obs_busy, 0);

    // Reset on the 4th cycle of an fdiv.
    idle();
    ex_valid = 1'b1; mc_start = 1'b1; mc_kind = 1'b1;
    repeat (3) cycle();
    rst_ni = 1'b0;
    repeat (2) cycle();
    rst_ni = 1'b1;
    idle();
    obs_busy = 0;
    repeat (3) cycle();
    check("after_reset_busy", obs_busy, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rs3      = 5'($urandom_range(0, 3));
      rs_used  = 3'($urandom);
      rs_f     = 3'($urandom);
      ex_valid = ($urandom_range(0, 7) != 0);
      ex_rd    = 5'($urandom_range(0, 3));
      wren_i   = 1'($urandom);
      wren_f   = 1'($urandom);
      wb_sel   = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom);
      mc_start = ($urandom_range(0, 9) == 0);
      mc_kind  = 1'($urandom);
      redirect = ($urandom_range(0, 7) == 0);
      rst_ni   = ($urandom_range(0, 149) != 0);
      cycle();
    end
    rst_ni = 1'b1;
    idle();
    repeat (FDIV_LAT + 2) cycle();

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
